// File: rtl/pipe_pkg.sv
// rtl/pipe_pkg.sv - shared types for the pipeline skid buffer
package pipe_pkg;

    localparam int CNT_W = 2;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_BUSY  = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

endpackage

// File: rtl/pipe_skid_buffer_if.sv
// rtl/pipe_skid_buffer_if.sv - upstream/downstream handshake bundle for the skid buffer
interface pipe_skid_buffer_if #(
    parameter int WIDTH = 8
);
    import pipe_pkg::*;

    logic             s_valid;
    logic             s_ready;
    logic [WIDTH-1:0] s_data;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic [CNT_W-1:0] count;

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, count
    );

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, count
    );

endinterface

// File: rtl/pipe_en_reg.sv
// rtl/pipe_en_reg.sv - enabled payload register with asynchronous active-low reset
module pipe_en_reg #(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= RESET_VALUE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/pipe_skid_buffer.sv
// rtl/pipe_skid_buffer.sv - two-entry registered valid/ready slice
module pipe_skid_buffer
    import pipe_pkg::*;
#(
    parameter int               WIDTH       = 8,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_skid_buffer_if.slave  bus
);

    skid_state_t      state;
    skid_state_t      next_state;
    logic             main_en;
    logic             skid_en;
    logic [WIDTH-1:0] main_d;
    logic [WIDTH-1:0] main_q;
    logic [WIDTH-1:0] skid_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_EMPTY;
        end else begin
            state <= next_state;
        end
    end

    // In FULL the upstream side is stalled, so main only ever reloads from skid there.
    always_comb begin
        next_state = state;
        main_en    = 1'b0;
        skid_en    = 1'b0;
        main_d     = bus.s_data;
        unique case (state)
            ST_EMPTY: begin
                if (bus.s_valid) begin
                    main_en    = 1'b1;
                    next_state = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (bus.s_valid && bus.m_ready) begin
                    main_en = 1'b1;
                end else if (bus.s_valid) begin
                    skid_en    = 1'b1;
                    next_state = ST_FULL;
                end else if (bus.m_ready) begin
                    next_state = ST_EMPTY;
                end
            end
            ST_FULL: begin
                main_d = skid_q;
                if (bus.m_ready) begin
                    main_en    = 1'b1;
                    next_state = ST_BUSY;
                end
            end
            default: begin
                next_state = ST_EMPTY;
            end
        endcase
    end

    pipe_en_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_main (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (main_en),
        .d     (main_d),
        .q     (main_q)
    );

    pipe_en_reg #(
        .WIDTH       (WIDTH),
        .RESET_VALUE (RESET_VALUE)
    ) u_skid (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (skid_en),
        .d     (bus.s_data),
        .q     (skid_q)
    );

    assign bus.m_valid = (state != ST_EMPTY);
    assign bus.s_ready = (state != ST_FULL);
    assign bus.m_data  = main_q;
    assign bus.count   = state;

endmodule

// File: tb/tb_pipe_skid_buffer.sv
// tb/tb_pipe_skid_buffer.sv - directed and randomized checks of pipe_skid_buffer
module tb_pipe_skid_buffer;

    logic clk;
    logic rst_n;
    int   checks;
    int   failures;

    pipe_skid_buffer_if #(.WIDTH(8)) bus ();

    pipe_skid_buffer #(
        .WIDTH       (8),
        .RESET_VALUE (8'h00)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string name, input logic mv, input logic [7:0] md,
                              input logic sr, input logic [1:0] cnt, input logic chk_data);
        checks++;
        if (bus.m_valid !== mv || bus.s_ready !== sr || bus.count !== cnt ||
            (chk_data && bus.m_data !== md)) begin
            failures++;
            $display("FAIL %s: got m_valid=%b m_data=%h s_ready=%b count=%0d, want m_valid=%b m_data=%h s_ready=%b count=%0d",
                     name, bus.m_valid, bus.m_data, bus.s_ready, bus.count, mv, md, sr, cnt);
        end
    endtask

    task automatic do_reset();
        bus.s_valid = 1'b0;
        bus.s_data  = 8'h00;
        bus.m_ready = 1'b0;
        rst_n       = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        #2;
    endtask

    task automatic test_reset();
        do_reset();
        expect_out("reset_state", 1'b0, 8'h00, 1'b1, 2'd0, 1'b1);
    endtask

    task automatic test_single();
        bus.s_valid = 1'b1;
        bus.s_data  = 8'hA5;
        bus.m_ready = 1'b1;
        step();
        expect_out("single_latency", 1'b1, 8'hA5, 1'b1, 2'd1, 1'b1);
        bus.s_valid = 1'b0;
        step();
        expect_out("single_drained", 1'b0, 8'hA5, 1'b1, 2'd0, 1'b0);
    endtask

    task automatic test_stream();
        bus.m_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            bus.s_valid = 1'b1;
            bus.s_data  = 8'(i);
            step();
            expect_out($sformatf("stream_%0d", i), 1'b1, 8'(i), 1'b1, 2'd1, 1'b1);
        end
        bus.s_valid = 1'b0;
        step();
        expect_out("stream_empty", 1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
    endtask

    task automatic fill_full(input logic [7:0] a, input logic [7:0] b);
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = a;
        step();
        bus.s_data  = b;
        step();
    endtask

    task automatic test_full_drain();
        bus.m_ready = 1'b0;
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h11;
        step();
        expect_out("busy_11", 1'b1, 8'h11, 1'b1, 2'd1, 1'b1);
        bus.s_data = 8'h22;
        step();
        expect_out("full_held", 1'b1, 8'h11, 1'b0, 2'd2, 1'b1);
        bus.s_valid = 1'b0;
        step();
        expect_out("full_stall_hold", 1'b1, 8'h11, 1'b0, 2'd2, 1'b1);
        bus.m_ready = 1'b1;
        step();
        expect_out("drain_first", 1'b1, 8'h22, 1'b1, 2'd1, 1'b1);
        step();
        expect_out("drain_second", 1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
    endtask

    task automatic test_full_boundary();
        fill_full(8'h11, 8'h22);
        expect_out("boundary_full", 1'b1, 8'h11, 1'b0, 2'd2, 1'b1);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h33;
        bus.m_ready = 1'b1;
        step();
        expect_out("boundary_only_drain", 1'b1, 8'h22, 1'b1, 2'd1, 1'b1);
        step();
        expect_out("boundary_33_accepted", 1'b1, 8'h33, 1'b1, 2'd1, 1'b1);
        bus.s_valid = 1'b0;
        step();
        expect_out("boundary_empty", 1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
        step();
        expect_out("empty_mready_noop", 1'b0, 8'h00, 1'b1, 2'd0, 1'b0);
    endtask

    task automatic test_reset_mid();
        fill_full(8'h44, 8'h55);
        expect_out("pre_reset_full", 1'b1, 8'h44, 1'b0, 2'd2, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        expect_out("async_reset", 1'b0, 8'h00, 1'b1, 2'd0, 1'b1);
        bus.s_valid = 1'b1;
        bus.s_data  = 8'h66;
        bus.m_ready = 1'b0;
        step();
        expect_out("reset_ignores_input", 1'b0, 8'h00, 1'b1, 2'd0, 1'b1);
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b1;
        #3;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            expect_out($sformatf("post_reset_%0d", i), 1'b0, 8'h00, 1'b1, 2'd0, 1'b1);
        end
    endtask

    task automatic test_random();
        logic [7:0] q[$];
        logic [7:0] next_data;
        logic [7:0] held;
        logic       push;
        logic       pop;
        logic       hold;
        int         sent;
        int         recvd;
        int         cyc;
        int         shown;
        next_data   = 8'h00;
        sent        = 0;
        recvd       = 0;
        cyc         = 0;
        shown       = 0;
        bus.s_valid = 1'b0;
        bus.m_ready = 1'b0;
        while (recvd < 10000 && cyc < 60000) begin
            if (!bus.s_valid && sent < 10000 && $urandom_range(0, 1) == 1) begin
                bus.s_valid = 1'b1;
                bus.s_data  = next_data;
            end
            bus.m_ready = 1'($urandom_range(0, 1));
            push = bus.s_valid && bus.s_ready;
            pop  = bus.m_valid && bus.m_ready;
            hold = bus.m_valid && !bus.m_ready;
            held = bus.m_data;
            if (pop) begin
                checks++;
                if (q.size() == 0 || bus.m_data !== q[0]) begin
                    failures++;
                    if (shown < 10) begin
                        shown++;
                        $display("FAIL rand_order: got %h, want %h (queue size %0d)",
                                 bus.m_data, (q.size() != 0) ? q[0] : 8'hxx, q.size());
                    end
                end
                if (q.size() != 0) void'(q.pop_front());
                recvd++;
            end
            if (push) begin
                q.push_back(bus.s_data);
                sent++;
                next_data++;
            end
            step();
            cyc++;
            if (push) bus.s_valid = 1'b0;
            if (hold) begin
                checks++;
                if (bus.m_data !== held) begin
                    failures++;
                    if (shown < 10) begin
                        shown++;
                        $display("FAIL rand_hold: m_data got %h, want %h", bus.m_data, held);
                    end
                end
            end
            checks++;
            if (int'(bus.count) != q.size()) begin
                failures++;
                if (shown < 10) begin
                    shown++;
                    $display("FAIL rand_count: got %0d, want %0d", bus.count, q.size());
                end
            end
        end
        checks++;
        if (recvd < 10000) begin
            failures++;
            $display("FAIL rand_timeout: received %0d words, want 10000", recvd);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b1;
        test_reset();
        test_single();
        test_stream();
        test_full_drain();
        test_full_boundary();
        test_reset_mid();
        do_reset();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
